// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: unit selects, shift modes, flag bit positions, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

  // unit_sel encodings
  localparam logic [2:0] UNIT_ADD = 3'b000;  // add / sub
  localparam logic [2:0] UNIT_AND = 3'b001;  // and / nand
  localparam logic [2:0] UNIT_SHF = 3'b010;  // barrel shift
  localparam logic [2:0] UNIT_SRC = 3'b011;  // pass src
  localparam logic [2:0] UNIT_OR  = 3'b100;
  localparam logic [2:0] UNIT_XOR = 3'b101;
  localparam logic [2:0] UNIT_MUL = 3'b110;  // iterative multiply
  localparam logic [2:0] UNIT_ACC = 3'b111;  // pass acc

  // shift_mode encodings; 2'b11 behaves as logical
  localparam logic [1:0] SH_LOG = 2'b00;
  localparam logic [1:0] SH_ARI = 2'b01;
  localparam logic [1:0] SH_ROT = 2'b10;

  // flags_out bit positions: {Z,N,C,V}
  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// Latency: busy for WIDTH cycles after start; done/product are valid combinationally in the last busy cycle.
// Backpressure: start is ignored while busy; the caller must not rely on it being queued.
//
// Ports:
//   clk_in, rst_n_in  clock, synchronous active-low reset (aborts any multiply in flight)
//   start             load operands and begin (only when not busy)
//   multiplicand      operand A, captured on start
//   multiplier        operand B, captured on start
//   busy              multiply in progress
//   done              high during the final iteration; product holds the full result then
//   product           2*WIDTH result (only meaningful while done is high)
module alu_seq_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;

  logic [WIDTH-1:0]   mplier_sh;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] sum;
  logic               last;

  always_comb begin
    // Shift then take bit 0 rather than indexing with the wider counter.
    mplier_sh = mplier_q >> cnt_q;
    addend    = mplier_sh[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;
    sum       = acc_q + addend;
    last      = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;

    if (start && !busy_q) begin
      mcand_d  = multiplicand;
      mplier_d = multiplier;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d = sum;
      cnt_d = cnt_q + CNT_W'(1);
      if (last) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  // The final partial sum is handed out before it is registered so the
  // owner can latch it on the same edge that ends the multiply.
  assign busy    = busy_q;
  assign done    = last;
  assign product = sum;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/done handshake: single-cycle logic/arith/shift units plus an iterative multiply.
// Latency: 1 cycle for single-cycle ops (back-to-back accepted), WIDTH+1 cycles for multiply.
// Backpressure: start_in is accepted only when busy_out is low; starts during a multiply are dropped.
//
// Ports:
//   clk_in, rst_n_in   clock, synchronous active-low reset
//   start_in           request, accepted when start_in & ~busy_out
//   unit_sel_in        function unit (see alu_pkg UNIT_*)
//   op_sel_in          add/sub, and/nand, shift left/right
//   shift_mode_in      logical / arithmetic / rotate (see alu_pkg SH_*)
//   acc_in, src_in     operands A and B; src_in low bits are also the shift amount
//   busy_out           multiply in flight
//   done_out           one-cycle pulse when res_out/res_hi_out/flags_out update
//   res_out            result (product low half for mul)
//   res_hi_out         product high half for mul, else 0
//   flags_out          {Z,N,C,V}, held between done pulses
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [2:0]       unit_sel_in,
  input  logic             op_sel_in,
  input  logic [1:0]       shift_mode_in,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] src_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] res_out,
  output logic [WIDTH-1:0] res_hi_out,
  output logic [3:0]       flags_out
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;

  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = x[WIDTH-1-i];
    end
    return r;
  endfunction

  // ---------------- add / sub ----------------
  // Subtract is A + ~B + 1, so carry-out 1 means "no borrow".
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   add_full;

  always_comb begin
    b_eff    = op_sel_in ? ~src_in : src_in;
    add_full = {1'b0, acc_in} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_sel_in};
  end

  // ---------------- barrel shifter ----------------
  // Only a left-shifting ladder exists; right shifts reverse the operand on
  // the way in and out. Vacated bits take the fill bit, which is the sign
  // only for arithmetic right shifts. Rotate feeds the shifted-out bits back.
  logic [SHAMT_W-1:0] shamt;
  logic               sh_right;
  logic               sh_rot;
  logic               sh_fill;
  logic [WIDTH-1:0]   sh_x;
  logic [WIDTH-1:0]   shift_res;

  always_comb begin
    shamt    = src_in[SHAMT_W-1:0];
    sh_right = op_sel_in;
    sh_rot   = (shift_mode_in == SH_ROT);
    sh_fill  = sh_right && (shift_mode_in == SH_ARI) && acc_in[WIDTH-1];
    sh_x     = sh_right ? bit_rev(acc_in) : acc_in;
    for (int i = 0; i < SHAMT_W; i++) begin
      if (shamt[i]) begin
        sh_x = (sh_x << (1 << i))
             | (sh_rot  ? (sh_x >> (WIDTH - (1 << i)))
              : sh_fill ? ~({WIDTH{1'b1}} << (1 << i))
              :           {WIDTH{1'b0}});
      end
    end
    shift_res = sh_right ? bit_rev(sh_x) : sh_x;
  end

  // ---------------- single-cycle result mux ----------------
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (unit_sel_in)
      UNIT_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (acc_in[WIDTH-1] == b_eff[WIDTH-1]) &&
                  (add_full[WIDTH-1] != acc_in[WIDTH-1]);
      end
      UNIT_AND: alu_res = op_sel_in ? ~(acc_in & src_in) : (acc_in & src_in);
      UNIT_SHF: alu_res = shift_res;
      UNIT_SRC: alu_res = src_in;
      UNIT_OR:  alu_res = acc_in | src_in;
      UNIT_XOR: alu_res = acc_in ^ src_in;
      UNIT_ACC: alu_res = acc_in;
      default:  alu_res = '0;  // UNIT_MUL goes through the multiplier
    endcase
  end

  // ---------------- multiplier ----------------
  alu_seq_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .start        (mul_start),
    .multiplicand (acc_in),
    .multiplier   (src_in),
    .busy         (mul_busy),
    .done         (mul_done),
    .product      (mul_product)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && (unit_sel_in == UNIT_MUL)) state_d = MUL;
      MUL:     if (mul_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    accept    = start_in && (state_q == IDLE);
    mul_start = accept && (unit_sel_in == UNIT_MUL);
    busy_out  = mul_busy;
  end

  // ---------------- result registers ----------------
  always_comb begin
    res_d    = res_q;
    res_hi_d = res_hi_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    if ((state_q == MUL) && mul_done) begin
      res_d          = mul_product[WIDTH-1:0];
      res_hi_d       = mul_product[2*WIDTH-1:WIDTH];
      flags_d[FLG_Z] = (mul_product[WIDTH-1:0] == '0);
      flags_d[FLG_N] = mul_product[WIDTH-1];
      flags_d[FLG_C] = |mul_product[2*WIDTH-1:WIDTH];
      flags_d[FLG_V] = 1'b0;
      done_d         = 1'b1;
    end else if (accept && (unit_sel_in != UNIT_MUL)) begin
      res_d          = alu_res;
      res_hi_d       = '0;
      flags_d[FLG_Z] = (alu_res == '0);
      flags_d[FLG_N] = alu_res[WIDTH-1];
      flags_d[FLG_C] = alu_c;
      flags_d[FLG_V] = alu_v;
      done_d         = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      res_q    <= '0;
      res_hi_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  assign done_out   = done_q;
  assign res_out    = res_q;
  assign res_hi_out = res_hi_q;
  assign flags_out  = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed corner cases plus randomized ops against an arithmetic reference model.
// Latency: checks done timing for single-cycle and multiply ops.
// Backpressure: checks that starts during a multiply are dropped and starts on the done cycle are taken.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int M8 = 255;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit DUT
  logic       rst_n;
  logic       start;
  logic [2:0] unit;
  logic       op;
  logic [1:0] mode;
  logic [7:0] acc, src;
  logic       busy, done;
  logic [7:0] res, res_hi;
  logic [3:0] flags;

  // 16-bit DUT
  logic        start16;
  logic [2:0]  unit16;
  logic        op16;
  logic [1:0]  mode16;
  logic [15:0] acc16, src16;
  logic        busy16, done16;
  logic [15:0] res16, hi16;
  logic [3:0]  flags16;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(8)) u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .unit_sel_in(unit),
    .op_sel_in(op), .shift_mode_in(mode), .acc_in(acc), .src_in(src),
    .busy_out(busy), .done_out(done), .res_out(res), .res_hi_out(res_hi),
    .flags_out(flags)
  );

  alu_seq #(.WIDTH(16)) u_dut16 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start16), .unit_sel_in(unit16),
    .op_sel_in(op16), .shift_mode_in(mode16), .acc_in(acc16), .src_in(src16),
    .busy_out(busy16), .done_out(done16), .res_out(res16), .res_hi_out(hi16),
    .flags_out(flags16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 8-bit operands.
  task automatic model(input int u, input int o, input int md, input int a, input int b,
                       output int r, output int hi, output logic [3:0] f);
    int c, v, s, sa, sign_a, sign_b, sign_r;
    c = 0; v = 0; hi = 0; r = 0;
    sign_a = (a >> 7) & 1;
    sign_b = (b >> 7) & 1;
    case (u)
      0: begin
        if (o == 0) begin
          r = (a + b) & M8;
          c = ((a + b) > M8) ? 1 : 0;
          sign_r = (r >> 7) & 1;
          v = (sign_a == sign_b && sign_r != sign_a) ? 1 : 0;
        end else begin
          r = (a - b) & M8;
          c = (a >= b) ? 1 : 0;
          sign_r = (r >> 7) & 1;
          v = (sign_a != sign_b && sign_r != sign_a) ? 1 : 0;
        end
      end
      1: r = (o != 0) ? (~(a & b)) & M8 : (a & b);
      2: begin
        s = b % 8;
        if (o == 0) begin
          if (md == 2) r = ((a << s) | (a >> (8 - s))) & M8;
          else         r = (a << s) & M8;
        end else begin
          if (md == 2) r = ((a >> s) | (a << (8 - s))) & M8;
          else if (md == 1) begin
            sa = (a > 127) ? a - 256 : a;
            r  = (sa >>> s) & M8;
          end else r = a >> s;
        end
      end
      3: r = b;
      4: r = a | b;
      5: r = a ^ b;
      6: begin
        r  = (a * b) & M8;
        hi = (a * b) >> 8;
        c  = (hi != 0) ? 1 : 0;
      end
      default: r = a;
    endcase
    f[3] = (r == 0);
    f[2] = (r > 127);
    f[1] = (c != 0);
    f[0] = (v != 0);
  endtask

  // Issue one op, wait (bounded) for done, check latency, busy length, result and hold.
  task automatic run_op(input string tag, input int u, input int o, input int md, input int a, input int b);
    int r, hi, lat, bcnt;
    logic [3:0] f;
    model(u, o, md, a, b, r, hi, f);
    @(negedge clk);
    start = 1'b1; unit = 3'(u); op = 1'(o); mode = 2'(md); acc = 8'(a); src = 8'(b);
    @(negedge clk);
    // Scramble inputs after the accepting edge; they must not matter.
    start = 1'b0; unit = 3'($urandom); op = 1'($urandom); acc = 8'($urandom); src = 8'($urandom);
    lat = 1; bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_lat"}, 64'(lat), 64'((u == 6) ? 9 : 1));
    chk({tag, "_busy"}, 64'(bcnt), 64'((u == 6) ? 8 : 0));
    chk({tag, "_res"}, 64'(res), 64'(r));
    chk({tag, "_hi"}, 64'(res_hi), 64'(hi));
    chk({tag, "_flags"}, 64'(flags), 64'(f));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(done), 64'(0));
    chk({tag, "_hold"}, 64'(res), 64'(r));
  endtask

  task automatic mul16(input string tag, input longint a, input longint b);
    int lat;
    longint p;
    p = a * b;
    @(negedge clk);
    start16 = 1'b1; acc16 = 16'(a); src16 = 16'(b);
    @(negedge clk);
    start16 = 1'b0; acc16 = 16'($urandom); src16 = 16'($urandom);
    lat = 1;
    while (!done16 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(17));
    chk({tag, "_prod"}, 64'({hi16, res16}), 64'(p));
    chk({tag, "_c"}, 64'(flags16[FLG_C]), 64'(((p >> 16) != 0) ? 1 : 0));
  endtask

  initial begin
    int nd, dlat, dres, lat, u;
    int br[6];
    logic [3:0] bf[6];
    int bhi;

    rst_n = 1'b0; start = 1'b0; unit = '0; op = 1'b0; mode = '0; acc = '0; src = '0;
    start16 = 1'b0; unit16 = UNIT_MUL; op16 = 1'b0; mode16 = '0; acc16 = '0; src16 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_res", 64'(res), 64'(0));
    chk("rst_hi", 64'(res_hi), 64'(0));
    chk("rst_flags", 64'(flags), 64'(0));
    rst_n = 1'b1;

    // Directed vectors with hand-derived expectations
    run_op("add7f", 0, 0, 0, 'h7F, 'h01);
    chk("add7f_k", 64'({res, flags}), 64'({8'h80, 4'b0101}));
    run_op("sub55", 0, 1, 0, 'h05, 'h05);
    chk("sub55_k", 64'({res, flags}), 64'({8'h00, 4'b1010}));
    run_op("sra", 2, 1, 1, 'h90, 'h03);
    chk("sra_k", 64'(res), 64'(8'hF2));
    run_op("rol", 2, 0, 2, 'h81, 'h01);
    chk("rol_k", 64'(res), 64'(8'h03));
    run_op("sh0", 2, 1, 2, 'hA5, 'h08);
    chk("sh0_k", 64'(res), 64'(8'hA5));
    run_op("mulff", 6, 0, 0, 'hFF, 'hFF);
    chk("mulff_k", 64'({res_hi, res, flags}), 64'({16'hFE01, 4'b0010}));

    // Start during multiply: ignored, exactly one done
    @(negedge clk);
    start = 1'b1; unit = UNIT_MUL; acc = 8'h0D; src = 8'h0B;
    nd = 0; dlat = 0; dres = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (done) begin nd++; dlat = k; dres = int'(res); end
      if (k == 1) start = 1'b0;
      if (k == 3) begin
        chk("ign_busy", 64'(busy), 64'(1));
        start = 1'b1; unit = UNIT_ADD; op = 1'b0; acc = 8'h01; src = 8'h01;
      end
      if (k == 4) start = 1'b0;
    end
    chk("ign_ndone", 64'(nd), 64'(1));
    chk("ign_lat", 64'(dlat), 64'(9));
    chk("ign_res", 64'(dres), 64'(8'h8F));

    // Start on the multiply done cycle is accepted
    @(negedge clk);
    start = 1'b1; unit = UNIT_MUL; acc = 8'h03; src = 8'h05;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk("dc_mul_lat", 64'(lat), 64'(9));
    chk("dc_mul_res", 64'(res), 64'(8'h0F));
    chk("dc_busy", 64'(busy), 64'(0));
    start = 1'b1; unit = UNIT_ADD; op = 1'b0; acc = 8'h10; src = 8'h20;
    @(negedge clk);
    start = 1'b0;
    chk("dc_add_done", 64'(done), 64'(1));
    chk("dc_add_res", 64'({res_hi, res, flags}), 64'({8'h00, 8'h30, 4'b0000}));

    // Reset in multiply cycle 4 aborts without a done
    @(negedge clk);
    start = 1'b1; unit = UNIT_MUL; acc = 8'hFF; src = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_out", 64'({busy, done, res, res_hi, flags}), 64'(0));
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mrst_nodone", 64'(nd), 64'(0));
    run_op("mrst_after", 6, 0, 0, 'h12, 'h34);

    // Back-to-back single-cycle ops: one done per cycle
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j > 0) begin
        chk("b2b_done", 64'(done), 64'(1));
        chk("b2b_res", 64'({res, flags}), 64'({8'(br[j-1]), bf[j-1]}));
      end
      u = int'($urandom_range(0, 7));
      if (u == 6) u = 7;
      start = 1'b1; unit = 3'(u); op = 1'($urandom); mode = 2'($urandom);
      acc = 8'($urandom); src = 8'($urandom);
      model(u, int'(op), int'(mode), int'(acc), int'(src), br[j], bhi, bf[j]);
    end
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done", 64'(done), 64'(1));
    chk("b2b_res", 64'({res, flags}), 64'({8'(br[5]), bf[5]}));

    // Randomized ops against the model
    for (int t = 0; t < 150; t++) begin
      run_op("rnd", int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    // 16-bit instance
    mul16("m16_dir", 64'h1234, 64'h0100);
    chk("m16_dir_k", 64'({hi16, res16}), 64'(32'h0012_3400));
    for (int t = 0; t < 8; t++) begin
      mul16("m16_rnd", longint'($urandom_range(0, 65535)), longint'($urandom_range(0, 65535)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
